bit_serial_sub_ctrl: RTL



---
 rtl/bit_serial_sub_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/bit_serial_sub_ctrl.sv
// Bit-serial subtractor sequencer: diff = a - b - bin, one bit per clock, LSB first.
// Define BSUB_FLAGS_EN to add the registered zero/neg/ovf result flags.
module bit_serial_sub_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef BSUB_FLAGS_EN
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`else
  output logic             bout
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] diff_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic [WIDTH-1:0] diff_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             bout_r;
  logic             busy_r;
  logic             done_r;
  logic             busy_next_s;
  logic             done_next_s;
  logic             accept_s;
  logic             step_s;
  logic             last_bit_s;
  logic             enter_done_s;
  logic             cell_d_s;
  logic             cell_bout_s;

  // Single full-subtractor cell, returns {borrow_out, difference}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    full_sub = {((~x) & y) | ((~(x ^ y)) & bi), x ^ y ^ bi};
  endfunction

  assign {cell_bout_s, cell_d_s} = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
  assign accept_s     = start && (state_r != RUN);
  assign step_s       = (state_r == RUN) && !abort;
  assign last_bit_s   = (cnt_r == CNT_W'(WIDTH - 1));
  assign enter_done_s = step_s && last_bit_s;
  assign diff_next_s  = {cell_d_s, diff_sh_r[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort takes priority over completion in RUN.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      RUN: begin
        if (abort)           next_state_s = IDLE;
        else if (last_bit_s) next_state_s = DONE;
        else                 next_state_s = RUN;
      end
      DONE: begin
        if (start) next_state_s = RUN;
        else       next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Output decode, registered below so busy/done come straight from flops.
  always_comb begin
    busy_next_s = (next_state_s == RUN);
    done_next_s = enter_done_s;
  end

  // Handshake output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
    end
  end

  // Operand shift registers, running borrow and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      diff_sh_r <= '0;
      borrow_r  <= 1'b0;
      cnt_r     <= '0;
    end else if (accept_s) begin
      a_sh_r    <= a;
      b_sh_r    <= b;
      diff_sh_r <= '0;
      borrow_r  <= bin;
      cnt_r     <= '0;
    end else if (step_s) begin
      a_sh_r    <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r    <= {1'b0, b_sh_r[WIDTH-1:1]};
      diff_sh_r <= diff_next_s;
      borrow_r  <= cell_bout_s;
      cnt_r     <= cnt_r + CNT_W'(1);
    end else begin
      a_sh_r    <= a_sh_r;
      b_sh_r    <= b_sh_r;
      diff_sh_r <= diff_sh_r;
      borrow_r  <= borrow_r;
      cnt_r     <= cnt_r;
    end
  end

  // Result registers: updated only when the last bit completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= '0;
      bout_r <= 1'b0;
    end else if (enter_done_s) begin
      diff_r <= diff_next_s;
      bout_r <= cell_bout_s;
    end else begin
      diff_r <= diff_r;
      bout_r <= bout_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;

`ifdef BSUB_FLAGS_EN
  logic a_msb_r;
  logic b_msb_r;
  logic zero_r;
  logic neg_r;
  logic ovf_r;

  // Operand sign capture and flag registers, held like diff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_r <= 1'b0;
      b_msb_r <= 1'b0;
      zero_r  <= 1'b0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        a_msb_r <= a[WIDTH-1];
        b_msb_r <= b[WIDTH-1];
      end else begin
        a_msb_r <= a_msb_r;
        b_msb_r <= b_msb_r;
      end
      if (enter_done_s) begin
        zero_r <= (diff_next_s == '0);
        neg_r  <= diff_next_s[WIDTH-1];
        ovf_r  <= (a_msb_r != b_msb_r) && (diff_next_s[WIDTH-1] != a_msb_r);
      end else begin
        zero_r <= zero_r;
        neg_r  <= neg_r;
        ovf_r  <= ovf_r;
      end
    end
  end

  assign zero = zero_r;
  assign neg  = neg_r;
  assign ovf  = ovf_r;
`endif

endmodule
